// File: rtl/hr_inject_sched_pkg.sv
// hr_inject_sched_pkg: shared encodings and constants for the ring injection scheduler.
package hr_inject_sched_pkg;
   localparam int FLIT_W = 144;
   localparam logic [1:0] SEL_RING = 2'b00;
   localparam logic [1:0] SEL_F0 = 2'b01;
   localparam logic [1:0] SEL_F1 = 2'b10;
   typedef enum logic {NORMAL = 1'b0, STARVE = 1'b1} state_e;
   function automatic logic [1:0] sel_of(input logic [1:0] gnt);
      return gnt[0] ? SEL_F0 : gnt[1] ? SEL_F1 : SEL_RING;
   endfunction
endpackage

// File: rtl/hr_rr_arb2.sv
// hr_rr_arb2: two-input round-robin arbiter with an optional forced winner.
module hr_rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       force_en,
   input  logic       force_id,
   output logic [1:0] gnt,
   output logic       ptr
);
   // a forced requester wins outright; otherwise the pointer breaks ties
   always_comb gnt = (force_en && req[force_id]) ? (force_id ? 2'b10 : 2'b01) :
                     (&req) ? (ptr ? 2'b10 : 2'b01) : req;
   always_ff @(posedge clk or negedge rst)
      if (!rst) ptr <= 1'b0;
      else if (|gnt) ptr <= gnt[0];
endmodule

// File: rtl/hr_inject_sched.sv
// hr_inject_sched: schedules bridge FIFO injection into free ring slots,
// escalating to a bubble-requesting STARVE mode when a FIFO waits too long.
module hr_inject_sched
   import hr_inject_sched_pkg::*;
#(
   parameter int STARVE_MAX = 8,
   parameter int CNT_W = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ring_vld_i,
   input  logic       ne0_i,
   input  logic       ne1_i,
   input  logic       bfull_i,
   output logic       deQ0_o,
   output logic       deQ1_o,
   output logic [1:0] sel_o,
   output logic       bubble_req_o,
   output logic       starved_o
);
   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(STARVE_MAX);
   logic [1:0] ne, req, gnt, reach;
   logic [1:0][CNT_W-1:0] cnt, cnt_nxt;
   state_e state, state_nxt;
   logic sid, sid_nxt, ptr, inj;
   assign ne = {ne1_i, ne0_i};
   assign inj = !ring_vld_i && !bfull_i;
   assign req = inj ? ne : 2'b00;
   hr_rr_arb2 u_arb (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .force_en (state == STARVE),
      .force_id (sid),
      .gnt      (gnt),
      .ptr      (ptr)
   );
   assign deQ0_o = rst && gnt[0];
   assign deQ1_o = rst && gnt[1];
   assign sel_o = rst ? sel_of(gnt) : SEL_RING;
   assign bubble_req_o = state == STARVE;
   assign starved_o = state == STARVE;
   // the registered count also counts as reached so a limit that coincided with a STARVE exit re-arms
   always_comb
      for (int i = 0; i < 2; i++) begin
         cnt_nxt[i] = (!ne[i] || gnt[i]) ? '0 : (cnt[i] == MAX_C) ? cnt[i] : cnt[i] + 1'b1;
         reach[i] = (cnt[i] == MAX_C) || (cnt_nxt[i] == MAX_C);
      end
   always_comb begin
      state_nxt = (state == STARVE) ? ((gnt[sid] || !ne[sid]) ? NORMAL : STARVE) :
                  (|reach ? STARVE : NORMAL);
      sid_nxt = (state == NORMAL && |reach) ? ((&reach) ? ptr : reach[1]) : sid;
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state <= NORMAL;
         sid <= 1'b0;
         cnt <= '0;
      end else begin
         state <= state_nxt;
         sid <= sid_nxt;
         cnt <= cnt_nxt;
      end
endmodule

// File: tb/tb_hr_inject_sched.sv
// tb_hr_inject_sched: scoreboard bench for hr_inject_sched with a behavioural
// arbitration/starvation model, directed scenarios and randomized traffic.
module tb_hr_inject_sched;
   localparam int MAXW = 8;
   logic clk = 1'b0, rst = 1'b0, ring_vld = 1'b0, ne0 = 1'b0, ne1 = 1'b0, bfull = 1'b0;
   logic deq0, deq1, bub, stv;
   logic [1:0] sel;
   int checks = 0, errors = 0;
   logic [5:0] exp_q[$];
   bit m_stv;
   int m_sid, m_ptr;
   int m_w[2];

   hr_inject_sched #(.STARVE_MAX(MAXW), .CNT_W(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .ring_vld_i   (ring_vld),
      .ne0_i        (ne0),
      .ne1_i        (ne1),
      .bfull_i      (bfull),
      .deQ0_o       (deq0),
      .deQ1_o       (deq1),
      .sel_o        (sel),
      .bubble_req_o (bub),
      .starved_o    (stv)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_stv = 0;
      m_sid = 0;
      m_ptr = 0;
      m_w = '{0, 0};
   endfunction

   // one clock cycle of stimulus; the model predicts this cycle's outputs and its effect on the next
   task automatic step(input bit r, input bit rv, input bit bf, input bit n0, input bit n1);
      int g, wn[2], n[2];
      bit h0, h1;
      @(posedge clk);
      #1;
      rst = r; ring_vld = rv; bfull = bf; ne0 = n0; ne1 = n1;
      n[0] = n0; n[1] = n1;
      if (!r) begin
         model_reset();
         exp_q.push_back(6'b0);
         return;
      end
      g = -1;
      if (!rv && !bf) begin
         if (m_stv && n[m_sid] == 1) g = m_sid;
         else if (n0 && n1) g = m_ptr;
         else if (n0) g = 0;
         else if (n1) g = 1;
      end
      exp_q.push_back({g == 0, g == 1, (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00, m_stv, m_stv});
      for (int k = 0; k < 2; k++)
         wn[k] = (n[k] == 0 || g == k) ? 0 : (m_w[k] < MAXW ? m_w[k] + 1 : MAXW);
      if (m_stv) begin
         if (g == m_sid || n[m_sid] == 0) m_stv = 0;
      end else begin
         h0 = (m_w[0] == MAXW) || (wn[0] == MAXW);
         h1 = (m_w[1] == MAXW) || (wn[1] == MAXW);
         if (h0 || h1) begin
            m_stv = 1;
            m_sid = (h0 && h1) ? m_ptr : (h1 ? 1 : 0);
         end
      end
      if (g >= 0) m_ptr = 1 - g;
      m_w = wn;
   endtask

   // monitor: pops one prediction per cycle and checks safety invariants and wait bound
   int lo0 = 0, lo1 = 0;
   always @(negedge clk) begin
      logic [5:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("scoreboard {deq0,deq1,sel,bubble,starved}", {deq0, deq1, sel, bub, stv}, e);
      end
      chk("deq_onehot", deq0 && deq1, 0);
      chk("deq_without_ne", (deq0 && !ne0) || (deq1 && !ne1), 0);
      chk("sel_11", sel == 2'b11, 0);
      if (!rst) begin
         lo0 = 0; lo1 = 0;
      end else begin
         lo0 = (!ne0 || deq0) ? 0 : (!ring_vld && !bfull) ? lo0 + 1 : lo0;
         lo1 = (!ne1 || deq1) ? 0 : (!ring_vld && !bfull) ? lo1 + 1 : lo1;
      end
      chk("wait_bound", (lo0 <= MAXW) && (lo1 <= MAXW), 1);
   end

   initial begin
      int p;
      model_reset();
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 1);
      for (int i = 0; i < 4; i++) begin
         step(1, 0, 0, 1, 1);
         @(negedge clk);
         chk("rr_sequence_sel", sel, (i % 2) ? 2 : 1);
      end
      step(0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         step(1, i % 2, 1, 1, 1);
         @(negedge clk);
         chk("bfull_blocks", {deq0, deq1, sel}, 0);
      end
      step(0, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) begin
         step(1, 1, 0, 1, 0);
         @(negedge clk);
         chk("pre_starve_flag", stv, 0);
      end
      step(1, 0, 0, 1, 0);
      @(negedge clk);
      chk("starve_grant_f0", {deq0, sel, bub, stv}, 5'b10111);
      step(1, 0, 0, 1, 0);
      @(negedge clk);
      chk("bubble_drop", bub, 0);
      step(0, 0, 0, 0, 0);
      step(1, 0, 0, 1, 0);
      for (int i = 0; i < 8; i++) step(1, 1, 0, 1, 1);
      step(1, 0, 0, 1, 1);
      @(negedge clk);
      chk("both_limit_f1_first", {deq1, sel, stv}, 4'b1101);
      step(1, 0, 0, 1, 1);
      @(negedge clk);
      chk("one_normal_cycle", stv, 0);
      step(1, 0, 0, 1, 1);
      @(negedge clk);
      chk("reenter_for_f0", {deq0, sel, stv}, 4'b1011);
      step(0, 0, 0, 0, 0);
      for (int i = 0; i < 9; i++) step(1, 1, 0, 1, 1);
      @(negedge clk);
      chk("in_starve", stv, 1);
      #1;
      ring_vld = 0;
      rst = 0;
      #1;
      chk("async_reset_outputs", {deq0, deq1, sel, bub, stv}, 0);
      model_reset();
      step(1, 0, 0, 1, 1);
      @(negedge clk);
      chk("first_grant_after_reset", {deq0, sel}, 3'b101);
      for (int i = 0; i < 6000; i++) begin
         p = (i / 1000 % 3 == 0) ? 20 : (i / 1000 % 3 == 1) ? 50 : 90;
         step($urandom_range(0, 299) != 0, $urandom_range(0, 99) < p, $urandom_range(0, 4) == 0,
              $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7);
      end
      step(1, 0, 0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      chk("queue_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end
endmodule
